// File: rtl/circuit2_seq_ctrl.sv
// Resource-shared Circuit2 scheduler: one add/sub unit sequenced by an FSM over a valid/ready stream.
// Optional build macro CIRCUIT2_EARLY_SKIP_EN: skip the a-b step when d==e (f is unused then).
module circuit2_seq_ctrl #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [WIDTH-1:0]     c,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     x,
  output logic [WIDTH-1:0]     z,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] op_cnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    S_D   = 3'd1,
    S_E   = 3'd2,
    S_F   = 3'd3,
    S_CMP = 3'd4,
    S_OUT = 3'd5
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r, b_r, c_r;
  logic [WIDTH-1:0] d_r, e_r, f_r;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_y;
  logic             alu_sub;

  // x = min(d,e), doubled when d is the strictly smaller one
  function automatic logic [WIDTH-1:0] calc_x(input logic [WIDTH-1:0] d,
                                               input logic [WIDTH-1:0] e);
    logic             lt;
    logic [WIDTH-1:0] g;
    lt = (d < e);
    g  = lt ? d : e;
    return g << lt;
  endfunction

  function automatic logic [WIDTH-1:0] calc_z(input logic [WIDTH-1:0] d,
                                               input logic [WIDTH-1:0] e,
                                               input logic [WIDTH-1:0] f);
    logic             eq;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] h;
    eq = (d == e);
    g  = (d < e) ? d : e;
    h  = eq ? g : f;
    return h >> eq;
  endfunction

  // Shared ALU operand select: b for d and f, c for e; subtract only in S_F
  always_comb begin
    alu_b   = b_r;
    alu_sub = 1'b0;
    if (state == S_E) alu_b = c_r;
    if (state == S_F) alu_sub = 1'b1;
    alu_y = alu_sub ? (a_r - alu_b) : (a_r + alu_b);
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      x         <= '0;
      z         <= '0;
      op_cnt    <= '0;
      a_r       <= '0;
      b_r       <= '0;
      c_r       <= '0;
      d_r       <= '0;
      e_r       <= '0;
      f_r       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= b;
            c_r   <= c;
            state <= S_D;
          end
        end
        S_D: begin
          d_r   <= alu_y;
          state <= S_E;
        end
        S_E: begin
          e_r <= alu_y;
`ifdef CIRCUIT2_EARLY_SKIP_EN
          state <= (alu_y == d_r) ? S_CMP : S_F;
`else
          state <= S_F;
`endif
        end
        S_F: begin
          f_r   <= alu_y;
          state <= S_CMP;
        end
        S_CMP: begin
          x         <= calc_x(d_r, e_r);
          z         <= calc_z(d_r, e_r, f_r);
          out_valid <= 1'b1;
          state     <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            op_cnt    <= op_cnt + CNT_WIDTH'(1);
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_circuit2_seq_ctrl.sv
// Self-checking bench for circuit2_seq_ctrl: table vectors, hand-written corner sequences, random traffic.
module tb_circuit2_seq_ctrl;
  localparam int W  = 32;
  localparam int CW = 16;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a, b, c;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  x, z;
  logic          busy;
  logic [CW-1:0] op_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;

  circuit2_seq_ctrl #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .out_valid(out_valid), .out_ready(out_ready),
    .x(x), .z(z), .busy(busy), .op_cnt(op_cnt)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [W-1:0] a, b, c, x, z;
  } vec_t;
  vec_t tbl[4];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain modular arithmetic on the d/e/f definitions
  task automatic model(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic [W-1:0] ci,
                       output logic [W-1:0] xo, output logic [W-1:0] zo, output int lat);
    longint m, d, e, f;
    m = 64'h1_0000_0000;
    d = (longint'(ai) + longint'(bi)) % m;
    e = (longint'(ai) + longint'(ci)) % m;
    f = (longint'(ai) - longint'(bi) + m) % m;
    if (d < e) xo = W'((d * 2) % m);
    else       xo = W'(e);
    if (d == e) zo = W'(d / 2);
    else        zo = W'(f);
    lat = 4;
`ifdef CIRCUIT2_EARLY_SKIP_EN
    if (d == e) lat = 3;
`endif
  endtask

  // mode 0: quiet inputs; 1: random in_valid/operand noise while busy; 2: in_valid held high
  task automatic run_txn(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic [W-1:0] ci,
                         input logic [W-1:0] ex, input logic [W-1:0] ez, input int lat,
                         input int hold, input int mode, input string nm);
    int k;
    chk({nm, ".in_ready_idle"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; a = ai; b = bi; c = ci;
    @(posedge Clk); #1;
    if (mode == 0) in_valid = 1'b0;
    k = 0;
    while (out_valid !== 1'b1 && k < 12) begin
      if (mode == 1) begin
        in_valid = 1'($urandom_range(0, 1));
        a = $urandom; b = $urandom; c = $urandom;
      end
      @(posedge Clk); #1;
      k++;
    end
    chk({nm, ".latency"}, 64'(k), 64'(lat));
    chk({nm, ".x"}, 64'(x), 64'(ex));
    chk({nm, ".z"}, 64'(z), 64'(ez));
    chk({nm, ".busy"}, 64'(busy), 64'd1);
    for (int i = 0; i < hold; i++) begin
      @(posedge Clk); #1;
      chk({nm, ".hold_valid"}, 64'(out_valid), 64'd1);
      chk({nm, ".hold_x"}, 64'(x), 64'(ex));
      chk({nm, ".hold_z"}, 64'(z), 64'(ez));
      chk({nm, ".hold_in_ready"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge Clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    exp_cnt++;
    chk({nm, ".post_valid"}, 64'(out_valid), 64'd0);
    chk({nm, ".op_cnt"}, 64'(op_cnt), 64'(exp_cnt % 65536));
    chk({nm, ".post_in_ready"}, 64'(in_ready), 64'd1);
    chk({nm, ".post_x"}, 64'(x), 64'(ex));
    chk({nm, ".post_z"}, 64'(z), 64'(ez));
  endtask

  initial begin
    logic [W-1:0] mx, mz, ra, rb, rc;
    int           lat;

    tbl[0] = '{a: 32'd5,          b: 32'd3, c: 32'd1, x: 32'd6, z: 32'd2};
    tbl[1] = '{a: 32'd1,          b: 32'd2, c: 32'd5, x: 32'd6, z: 32'hFFFF_FFFF};
    tbl[2] = '{a: 32'd4,          b: 32'd2, c: 32'd2, x: 32'd6, z: 32'd3};
    tbl[3] = '{a: 32'hFFFF_FFFF,  b: 32'd1, c: 32'd0, x: 32'd0, z: 32'hFFFF_FFFE};

    Rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; c = '0;
    repeat (2) @(posedge Clk);
    #1;
    Rst = 1'b0;
    chk("reset.in_ready", 64'(in_ready), 64'd1);
    chk("reset.out_valid", 64'(out_valid), 64'd0);
    chk("reset.busy", 64'(busy), 64'd0);
    chk("reset.x", 64'(x), 64'd0);
    chk("reset.z", 64'(z), 64'd0);
    chk("reset.op_cnt", 64'(op_cnt), 64'd0);

    for (int i = 0; i < 4; i++) begin
      model(tbl[i].a, tbl[i].b, tbl[i].c, mx, mz, lat);
      run_txn(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].x, tbl[i].z, lat, 0, 0,
              $sformatf("vec%0d", i));
    end

    // Long backpressure with in_valid held high
    model(32'd5, 32'd3, 32'd1, mx, mz, lat);
    run_txn(32'd5, 32'd3, 32'd1, 32'd6, 32'd2, lat, 10, 2, "backpressure");

    // Reset while in S_E discards the transaction
    in_valid = 1'b1; a = 32'd7; b = 32'd9; c = 32'd1;
    @(posedge Clk); #1;
    in_valid = 1'b0;
    @(posedge Clk); #1;
    Rst = 1'b1;
    @(posedge Clk); #1;
    Rst = 1'b0;
    exp_cnt = 0;
    chk("midrst.in_ready", 64'(in_ready), 64'd1);
    chk("midrst.busy", 64'(busy), 64'd0);
    chk("midrst.out_valid", 64'(out_valid), 64'd0);
    chk("midrst.x", 64'(x), 64'd0);
    chk("midrst.z", 64'(z), 64'd0);
    chk("midrst.op_cnt", 64'(op_cnt), 64'd0);
    repeat (3) @(posedge Clk);
    #1;
    chk("midrst.no_output", 64'(out_valid), 64'd0);
    model(32'd1, 32'd2, 32'd5, mx, mz, lat);
    run_txn(32'd1, 32'd2, 32'd5, mx, mz, lat, 1, 0, "after_rst");

    for (int i = 0; i < 30; i++) begin
      ra = $urandom; rb = $urandom; rc = $urandom;
      if ($urandom_range(0, 3) == 0) rc = rb;
      if ($urandom_range(0, 5) == 0) rb = ~ra + 32'd1 + 32'($urandom_range(0, 2));
      model(ra, rb, rc, mx, mz, lat);
      run_txn(ra, rb, rc, mx, mz, lat, $urandom_range(0, 3), 1, $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
